// File: rtl/mem_bus_arbiter.sv
// Single-owner arbiter for the external memory bus shared by instruction fetch and the
// data-memory stage. One transaction at a time, with MEM-first priority bounded by a streak limit.
module mem_bus_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MEM_STREAK_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    // instruction fetch side
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ready,
    // data memory side
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_ready,
    // pipeline control
    input  logic                flash_from_execute,
    // external bus
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_be,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic                bus_ack,
    // stall indications
    output logic                stall_from_fetch,
    output logic                stall_from_memory
);

    localparam int BE_W     = DATA_W / 8;
    localparam int STREAK_W = 4;
    localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MEM_STREAK_MAX);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  bus_req_q, bus_req_d;
    logic                  bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]     bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]     bus_wdata_q, bus_wdata_d;
    logic [BE_W-1:0]       bus_be_q, bus_be_d;
    logic [DATA_W-1:0]     if_rdata_q, if_rdata_d;
    logic                  if_ready_q, if_ready_d;
    logic [DATA_W-1:0]     mem_rdata_q, mem_rdata_d;
    logic                  mem_ready_q, mem_ready_d;
    logic [STREAK_W-1:0]   streak_q, streak_d;
    logic                  drop_q, drop_d;

    logic                  idle_free;
    logic                  if_starved;
    logic                  grant_mem;
    logic                  grant_if;
    logic                  ack_seen;
    logic                  fetch_drop;

    // A ready cycle is IDLE but still shows the finished request, so no grant is made in it.
    assign idle_free  = (state_q == IDLE) && !if_ready_q && !mem_ready_q;
    assign if_starved = if_req && (streak_q == STREAK_LIMIT);
    assign grant_mem  = idle_free && mem_req && !if_starved;
    assign grant_if   = idle_free && !grant_mem && if_req && !flash_from_execute;
    assign ack_seen   = bus_req_q && bus_ack;
    assign fetch_drop = drop_q || flash_from_execute;

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        if_rdata_d  = if_rdata_q;
        if_ready_d  = 1'b0;
        mem_rdata_d = mem_rdata_q;
        mem_ready_d = 1'b0;
        streak_d    = streak_q;
        drop_d      = drop_q;

        case (state_q)
            IDLE: begin
                if (grant_mem) begin
                    state_d     = MEM_BUSY;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                    bus_be_d    = mem_be;
                    if (if_req) begin
                        streak_d = (streak_q == STREAK_LIMIT) ? streak_q : streak_q + 1'b1;
                    end else begin
                        streak_d = '0;
                    end
                end else if (grant_if) begin
                    state_d     = IF_BUSY;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = '0;
                    bus_be_d    = {BE_W{1'b1}};
                    streak_d    = '0;
                    drop_d      = 1'b0;
                end
            end

            IF_BUSY: begin
                if (ack_seen) begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                    drop_d    = 1'b0;
                    // A flushed fetch still finishes on the bus but is never delivered.
                    if (!fetch_drop) begin
                        if_rdata_d = bus_rdata;
                        if_ready_d = 1'b1;
                    end
                end else if (flash_from_execute) begin
                    drop_d = 1'b1;
                end
            end

            MEM_BUSY: begin
                if (ack_seen) begin
                    state_d     = IDLE;
                    bus_req_d   = 1'b0;
                    mem_rdata_d = bus_rdata;
                    mem_ready_d = 1'b1;
                end
            end

            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
                drop_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            if_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            mem_rdata_q <= '0;
            mem_ready_q <= 1'b0;
            streak_q    <= '0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            if_rdata_q  <= if_rdata_d;
            if_ready_q  <= if_ready_d;
            mem_rdata_q <= mem_rdata_d;
            mem_ready_q <= mem_ready_d;
            streak_q    <= streak_d;
            drop_q      <= drop_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_be    = bus_be_q;
    assign if_rdata  = if_rdata_q;
    assign if_ready  = if_ready_q;
    assign mem_rdata = mem_rdata_q;
    assign mem_ready = mem_ready_q;

    assign stall_from_fetch  = if_req && !if_ready_q;
    assign stall_from_memory = mem_req && !mem_ready_q;

`ifndef SYNTHESIS
    // Owners must hold their request for the whole transaction; a flushed fetch is exempt.
    a_mem_req_held: assert property (@(posedge clk) disable iff (rst)
        (state_q == MEM_BUSY) |-> mem_req);
    a_if_req_held: assert property (@(posedge clk) disable iff (rst)
        (state_q == IF_BUSY && !drop_q && !flash_from_execute) |-> if_req);
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: stimulus queues expected bus transactions and returned
// data; independent monitors compare them as the arbiter presents bus_req / ready pulses.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        flash_from_execute;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        stall_from_fetch;
    logic        stall_from_memory;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_t;

    typedef struct {
        int          lat;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        bit          chk;
        logic [31:0] data;
    } mem_exp_t;

    bus_t        exp_bus[$];
    resp_t       resp_q[$];
    logic [31:0] exp_if[$];
    mem_exp_t    exp_mem[$];

    int n_checks = 0;
    int n_fail   = 0;

    mem_bus_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .MEM_STREAK_MAX(4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .if_req            (if_req),
        .if_addr           (if_addr),
        .if_rdata          (if_rdata),
        .if_ready          (if_ready),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_be            (mem_be),
        .mem_rdata         (mem_rdata),
        .mem_ready         (mem_ready),
        .flash_from_execute(flash_from_execute),
        .bus_req           (bus_req),
        .bus_we            (bus_we),
        .bus_addr          (bus_addr),
        .bus_wdata         (bus_wdata),
        .bus_be            (bus_be),
        .bus_rdata         (bus_rdata),
        .bus_ack           (bus_ack),
        .stall_from_fetch  (stall_from_fetch),
        .stall_from_memory (stall_from_memory)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_bus(logic we, logic [31:0] addr, logic [31:0] wdata, logic [3:0] be);
        bus_t t;
        t.we = we; t.addr = addr; t.wdata = wdata; t.be = be;
        exp_bus.push_back(t);
    endtask

    task automatic push_resp(int lat, logic [31:0] data);
        resp_t r;
        r.lat = lat; r.data = data;
        resp_q.push_back(r);
    endtask

    task automatic push_mem(bit chk, logic [31:0] data);
        mem_exp_t m;
        m.chk = chk; m.data = data;
        exp_mem.push_back(m);
    endtask

    // Bus slave: acks after the queued number of wait cycles with the queued read data.
    initial begin
        int    cnt;
        bit    active;
        resp_t r;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        cnt       = 0;
        active    = 1'b0;
        r.lat     = 0;
        r.data    = 32'h0;
        forever begin
            @(negedge clk);
            if (bus_req && !bus_ack) begin
                if (!active) begin
                    active = 1'b1;
                    cnt    = 0;
                    if (resp_q.size() > 0) r = resp_q.pop_front();
                    else begin r.lat = 0; r.data = 32'h0; end
                end
                if (cnt == r.lat) begin
                    bus_ack   = 1'b1;
                    bus_rdata = r.data;
                    active    = 1'b0;
                end else begin
                    cnt++;
                end
            end else begin
                bus_ack = 1'b0;
                if (!bus_req) active = 1'b0;
            end
        end
    end

    // Monitor: bus transactions and ready pulses against the scoreboard queues.
    initial begin
        bit       prev_req;
        bus_t     cur;
        logic [31:0] e_if;
        mem_exp_t e_mem;
        prev_req = 1'b0;
        cur      = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 1'b0;
            end else begin
                if (bus_req && !prev_req) begin
                    if (exp_bus.size() == 0) begin
                        check("bus_unexpected_txn", bus_addr, 32'hFFFF_FFFF);
                    end else begin
                        cur = exp_bus.pop_front();
                        $display("bus txn we=%0b addr=0x%08h wdata=0x%08h be=0x%0h",
                                 bus_we, bus_addr, bus_wdata, bus_be);
                        check("bus_addr", bus_addr, cur.addr);
                        check("bus_we", {31'b0, bus_we}, {31'b0, cur.we});
                        check("bus_wdata", bus_wdata, cur.wdata);
                        check("bus_be", {28'b0, bus_be}, {28'b0, cur.be});
                    end
                end else if (bus_req) begin
                    check("bus_stable", {31'b0, (bus_we === cur.we && bus_addr === cur.addr &&
                          bus_wdata === cur.wdata && bus_be === cur.be)}, 32'd1);
                end
                prev_req = bus_req;
                if (if_ready) begin
                    if (exp_if.size() == 0) begin
                        check("if_ready_unexpected", {31'b0, if_ready}, 32'd0);
                    end else begin
                        e_if = exp_if.pop_front();
                        $display("fetch done rdata=0x%08h", if_rdata);
                        check("if_rdata", if_rdata, e_if);
                    end
                end
                if (mem_ready) begin
                    if (exp_mem.size() == 0) begin
                        check("mem_ready_unexpected", {31'b0, mem_ready}, 32'd0);
                    end else begin
                        e_mem = exp_mem.pop_front();
                        $display("data access done rdata=0x%08h", mem_rdata);
                        if (e_mem.chk) check("mem_rdata", mem_rdata, e_mem.data);
                    end
                end
            end
        end
    end

    // One requester active; checks ready latency (in cycles from the request) and stall.
    task automatic run_single(bit is_if, int exp_k, string name);
        bit seen;
        seen = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (is_if ? if_ready : mem_ready) begin
                seen = 1'b1;
                check({name, "_latency"}, k, exp_k);
                check({name, "_stall_ready"}, {31'b0, is_if ? stall_from_fetch : stall_from_memory}, 32'd0);
                if (is_if) if_req = 1'b0;
                else mem_req = 1'b0;
            end else begin
                check({name, "_stall"}, {31'b0, is_if ? stall_from_fetch : stall_from_memory}, 32'd1);
            end
        end
        if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Both requesters hold requests; after each ready the address steps by 4.
    task automatic run_pair(int if_n, int mem_n, int budget);
        int if_done;
        int mem_done;
        int k;
        if_done = 0; mem_done = 0; k = 0;
        if_req  = (if_n > 0);
        mem_req = (mem_n > 0);
        while ((if_done < if_n || mem_done < mem_n) && k < budget) begin
            @(negedge clk);
            k++;
            if (if_ready) begin
                if_done++;
                if (if_done < if_n) if_addr = if_addr + 32'd4;
                else if_req = 1'b0;
            end
            if (mem_ready) begin
                mem_done++;
                if (mem_done < mem_n) mem_addr = mem_addr + 32'd4;
                else mem_req = 1'b0;
            end
        end
        check("pair_complete", {31'b0, (if_done == if_n && mem_done == mem_n)}, 32'd1);
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        if_req = 1'b0; if_addr = 32'h0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_be = 4'h0;
        flash_from_execute = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_bus_req", {31'b0, bus_req}, 32'd0);
        check("rst_bus_we", {31'b0, bus_we}, 32'd0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("rst_bus_be", {28'b0, bus_be}, 32'h0);
        check("rst_if_ready", {31'b0, if_ready}, 32'd0);
        check("rst_mem_ready", {31'b0, mem_ready}, 32'd0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        check("rst_stall_fetch", {31'b0, stall_from_fetch}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single fetch, three wait cycles
        push_bus(1'b0, 32'h0040_0000, 32'h0, 4'hF);
        push_resp(3, 32'h3C01_ABCD);
        exp_if.push_back(32'h3C01_ABCD);
        if_req = 1'b1; if_addr = 32'h0040_0000;
        run_single(1'b1, 5, "fetch");
        @(negedge clk);

        // Store, immediate ack
        push_bus(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'h3);
        push_resp(0, 32'h5555_5555);
        push_mem(1'b0, 32'h0);
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h8000_0010;
        mem_wdata = 32'hDEAD_BEEF; mem_be = 4'h3;
        run_single(1'b0, 2, "store");
        mem_we = 1'b0; mem_wdata = 32'h0; mem_be = 4'hF;
        @(negedge clk);

        // Contention: four MEM grants, then IF gets its turn
        mem_addr = 32'h8000_0100; if_addr = 32'h0040_1000;
        push_bus(1'b0, 32'h8000_0100, 32'h0, 4'hF); push_resp(0, 32'hA000_0000); push_mem(1'b1, 32'hA000_0000);
        push_bus(1'b0, 32'h8000_0104, 32'h0, 4'hF); push_resp(0, 32'hA100_0000); push_mem(1'b1, 32'hA100_0000);
        push_bus(1'b0, 32'h8000_0108, 32'h0, 4'hF); push_resp(0, 32'hA200_0000); push_mem(1'b1, 32'hA200_0000);
        push_bus(1'b0, 32'h8000_010C, 32'h0, 4'hF); push_resp(0, 32'hA300_0000); push_mem(1'b1, 32'hA300_0000);
        push_bus(1'b0, 32'h0040_1000, 32'h0, 4'hF); push_resp(0, 32'hB000_0000); exp_if.push_back(32'hB000_0000);
        push_bus(1'b0, 32'h8000_0110, 32'h0, 4'hF); push_resp(0, 32'hA400_0000); push_mem(1'b1, 32'hA400_0000);
        push_bus(1'b0, 32'h8000_0114, 32'h0, 4'hF); push_resp(0, 32'hA500_0000); push_mem(1'b1, 32'hA500_0000);
        push_bus(1'b0, 32'h0040_1004, 32'h0, 4'hF); push_resp(0, 32'hB100_0000); exp_if.push_back(32'hB100_0000);
        run_pair(2, 6, 100);
        @(negedge clk);

        // Flush in the second IF_BUSY cycle: fetch dropped, redirected fetch served
        push_bus(1'b0, 32'h0040_0100, 32'h0, 4'hF); push_resp(3, 32'h1111_1111);
        push_bus(1'b0, 32'h0040_0200, 32'h0, 4'hF); push_resp(1, 32'h2222_2222);
        exp_if.push_back(32'h2222_2222);
        if_req = 1'b1; if_addr = 32'h0040_0100;
        seen = 1'b0;
        for (int k = 1; k <= 30 && !seen; k++) begin
            @(negedge clk);
            if (k == 2) flash_from_execute = 1'b1;
            if (k == 3) begin
                flash_from_execute = 1'b0;
                if_addr = 32'h0040_0200;
            end
            if (k == 5) begin
                check("flush_no_ready", {31'b0, if_ready}, 32'd0);
                check("flush_rdata_kept", if_rdata, 32'hB100_0000);
            end
            if (if_ready) begin
                seen = 1'b1;
                check("refetch_latency", k, 8);
                if_req = 1'b0;
            end
        end
        if (!seen) check("refetch_timeout", 32'd0, 32'd1);
        @(negedge clk);

        // Flush in the same cycle as a new fetch request blocks the grant
        push_bus(1'b0, 32'h0040_0300, 32'h0, 4'hF); push_resp(0, 32'h3333_3333);
        exp_if.push_back(32'h3333_3333);
        if_req = 1'b1; if_addr = 32'h0040_0300; flash_from_execute = 1'b1;
        seen = 1'b0;
        for (int k = 1; k <= 30 && !seen; k++) begin
            @(negedge clk);
            if (k <= 2) check("flush_grant_no_bus", {31'b0, bus_req}, 32'd0);
            if (k == 2) flash_from_execute = 1'b0;
            if (k == 3) check("flush_grant_bus", {31'b0, bus_req}, 32'd1);
            if (if_ready) begin
                seen = 1'b1;
                check("flush_grant_latency", k, 4);
                if_req = 1'b0;
            end
        end
        if (!seen) check("flush_grant_timeout", 32'd0, 32'd1);
        @(negedge clk);

        // Asynchronous reset during MEM_BUSY
        push_bus(1'b0, 32'h8000_0020, 32'h0, 4'hF); push_resp(10, 32'h0BAD_F00D);
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h8000_0020; mem_wdata = 32'h0; mem_be = 4'hF;
        if_req = 1'b1; if_addr = 32'h0040_2000;
        @(negedge clk);
        check("pre_rst_bus_req", {31'b0, bus_req}, 32'd1);
        check("pre_rst_streak", {28'b0, dut.streak_q}, 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_bus_req", {31'b0, bus_req}, 32'd0);
        check("async_rst_bus_addr", bus_addr, 32'h0);
        check("async_rst_bus_be", {28'b0, bus_be}, 32'h0);
        check("async_rst_streak", {28'b0, dut.streak_q}, 32'd0);
        check("async_rst_state", {30'b0, dut.state_q}, 32'd0);
        check("async_rst_stall_mem", {31'b0, stall_from_memory}, 32'd1);
        mem_req = 1'b0; if_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Load after reset with two wait cycles
        push_bus(1'b0, 32'h8000_0040, 32'h0, 4'hF); push_resp(2, 32'hCAFE_F00D);
        push_mem(1'b1, 32'hCAFE_F00D);
        mem_req = 1'b1; mem_addr = 32'h8000_0040;
        run_single(1'b0, 4, "load");
        repeat (3) @(negedge clk);

        check("left_bus", exp_bus.size(), 32'd0);
        check("left_if", exp_if.size(), 32'd0);
        check("left_mem", exp_mem.size(), 32'd0);
        check("left_resp", resp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
